// File: rtl/ud_dir_ctrl_311_if.sv
// Bundle between the direction controller and the up/down counter it steers.
// The counter side holds the master modport; the controller is the slave.
interface ud_dir_ctrl_311_if #(
  parameter int W = 4
);
  logic         btn_311;
  logic         mode_311;
  logic [W-1:0] count_311;
  logic         ud_311;
  logic         dir_chg_311;

  modport master (
    output btn_311,
    output mode_311,
    output count_311,
    input  ud_311,
    input  dir_chg_311
  );

  modport slave (
    input  btn_311,
    input  mode_311,
    input  count_311,
    output ud_311,
    output dir_chg_311
  );
endinterface

// File: rtl/ud_dir_ctrl_311.sv
// Direction controller for the 4-bit up/down counter: manual button toggle or auto ping-pong sweep.
// Optional macro BTN_DEBOUNCE_EN enables the press/release debounce FSM; without it a press is an edge detect.
module ud_dir_ctrl_311 #(
  parameter int W         = 4,
  parameter int UPPER     = 15,
  parameter int LOWER     = 0,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk_311,
  input  logic             reset_311,
  ud_dir_ctrl_311_if.slave bus
);

  if ((UPPER - LOWER) < 2 || UPPER > ((1 << W) - 1) || DB_CYCLES < 2) begin : g_bad_cfg
    $error("ud_dir_ctrl_311: illegal UPPER/LOWER/DB_CYCLES combination");
  end

  // Trigger one step early: the counter registers our direction a cycle late.
  localparam logic [W-1:0] TRIG_UP = W'(UPPER - 1);
  localparam logic [W-1:0] TRIG_DN = W'(LOWER + 1);

  logic [1:0] r_sync;
  logic       w_btn_s;
  logic       w_press;
  logic       r_ud;
  logic       r_dir_chg;
  logic       w_ud_nxt;

  assign w_btn_s = r_sync[1];

  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], bus.btn_311};
    end
  end

`ifdef BTN_DEBOUNCE_EN
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  db_state_e     r_state;
  db_state_e     w_state_nxt;
  logic [CW-1:0] r_db_cnt;
  logic [CW-1:0] w_db_cnt_nxt;

  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      r_state  <= IDLE;
      r_db_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_db_cnt <= w_db_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_press      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt  = PRESS_WAIT;
          w_db_cnt_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_db_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_press     = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt  = REL_WAIT;
          w_db_cnt_nxt = '0;
        end else begin
          w_state_nxt = PRESSED;
        end
      end
      REL_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_db_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_db_cnt_nxt = r_db_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_db_cnt_nxt = '0;
      end
    endcase
  end
`else
  logic r_btn_d;
  logic r_press;

  // Registered edge detect puts the pulse three cycles after the raw button rises.
  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      r_btn_d <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_btn_d <= w_btn_s;
      r_press <= w_btn_s & ~r_btn_d;
    end
  end

  assign w_press = r_press;
`endif

  always_comb begin
    w_ud_nxt = r_ud;
    if (bus.mode_311) begin
      if (r_ud && (bus.count_311 == TRIG_UP)) begin
        w_ud_nxt = 1'b0;
      end else if (!r_ud && (bus.count_311 == TRIG_DN)) begin
        w_ud_nxt = 1'b1;
      end else begin
        w_ud_nxt = r_ud;
      end
    end else if (w_press) begin
      w_ud_nxt = ~r_ud;
    end else begin
      w_ud_nxt = r_ud;
    end
  end

  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      r_ud      <= 1'b1;
      r_dir_chg <= 1'b0;
    end else begin
      r_ud      <= w_ud_nxt;
      r_dir_chg <= w_ud_nxt ^ r_ud;
    end
  end

  assign bus.ud_311      = r_ud;
  assign bus.dir_chg_311 = r_dir_chg;

endmodule

// File: tb/tb_ud_dir_ctrl_311.sv
// Directed bench for ud_dir_ctrl_311: auto sweep against a counter, boundary forcing, manual presses.
// Debounce scenarios run when BTN_DEBOUNCE_EN is defined, edge-detect scenarios otherwise.
module tb_ud_dir_ctrl_311;

  logic       clk_311 = 1'b0;
  logic       reset_311;
  logic       use_model;
  logic [3:0] forced_cnt;
  logic [3:0] model_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;

  ud_dir_ctrl_311_if #(.W(4)) bus ();

  ud_dir_ctrl_311 #(
    .W(4), .UPPER(15), .LOWER(0), .DB_CYCLES(16)
  ) dut (
    .clk_311  (clk_311),
    .reset_311(reset_311),
    .bus      (bus)
  );

  always #5 clk_311 = ~clk_311;

  // Plain 4-bit up/down counter closing the loop, as in the real system.
  always_ff @(posedge clk_311) begin
    if (reset_311) model_cnt <= 4'd0;
    else if (bus.ud_311) model_cnt <= model_cnt + 4'd1;
    else model_cnt <= model_cnt - 4'd1;
  end

  assign bus.count_311 = use_model ? model_cnt : forced_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_311);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset_311 = 1'b1;
    tick(n);
    reset_311 = 1'b0;
  endtask

  initial begin
    reset_311     = 1'b1;
    bus.btn_311   = 1'b0;
    bus.mode_311  = 1'b1;
    use_model     = 1'b1;
    forced_cnt    = 4'd0;

    // Reset, then free-running auto sweep: triangle 0..15..0 with period 30.
    tick(8);
    reset_311 = 1'b0;
    check_val("rst_ud", bus.ud_311, 1);
    check_val("rst_dir", bus.dir_chg_311, 0);
    check_val("rst_cnt", bus.count_311, 0);
    for (int k = 1; k <= 70; k++) begin
      int p;
      tick(1);
      p = k % 30;
      check_val("sweep_cnt", bus.count_311, (p <= 15) ? p : 30 - p);
      check_val("sweep_dir", bus.dir_chg_311, (p == 0 || p == 15) ? 1 : 0);
      check_val("sweep_ud", bus.ud_311, (p < 15) ? 1 : 0);
    end

    // Auto boundaries with the count forced.
    use_model  = 1'b0;
    forced_cnt = 4'd7;
    do_reset(2);
    check_val("ab_start", bus.ud_311, 1);
    forced_cnt = 4'd14; tick(1);
    check_val("ab_up_rev_ud", bus.ud_311, 0);
    check_val("ab_up_rev_dir", bus.dir_chg_311, 1);
    forced_cnt = 4'd7; tick(1);
    check_val("ab_hold_ud", bus.ud_311, 0);
    check_val("ab_hold_dir", bus.dir_chg_311, 0);
    forced_cnt = 4'd1; tick(1);
    check_val("ab_dn_rev_ud", bus.ud_311, 1);
    check_val("ab_dn_rev_dir", bus.dir_chg_311, 1);
    forced_cnt = 4'd15; tick(1);
    check_val("ab_top_ud", bus.ud_311, 1);
    check_val("ab_top_dir", bus.dir_chg_311, 0);
    tick(2);
    check_val("ab_top_ud2", bus.ud_311, 1);
    forced_cnt = 4'd1; tick(1);
    check_val("ab_lowtrig_up", bus.ud_311, 1);
    forced_cnt = 4'd0; tick(1);
    check_val("ab_zero_up", bus.ud_311, 1);

    // Manual mode ignores the count.
    bus.mode_311 = 1'b0;
    forced_cnt   = 4'd14;
    tick(3);
    check_val("man_cnt_ignored", bus.ud_311, 1);

`ifndef BTN_DEBOUNCE_EN
    // Single-cycle press: toggle lands on the 4th edge after the button is sampled.
    bus.btn_311 = 1'b1; tick(1);
    bus.btn_311 = 1'b0; tick(2);
    check_val("pulse_early", bus.ud_311, 1);
    tick(1);
    check_val("pulse_ud", bus.ud_311, 0);
    check_val("pulse_dir", bus.dir_chg_311, 1);
    tick(1);
    check_val("pulse_dir_end", bus.dir_chg_311, 0);
    tick(5);
    check_val("pulse_once", bus.ud_311, 0);

    // Long hold gives one toggle; release gives none.
    bus.btn_311 = 1'b1; tick(10);
    check_val("hold_once", bus.ud_311, 1);
    bus.btn_311 = 1'b0; tick(6);
    check_val("release_none", bus.ud_311, 1);

    // Auto mode ignores presses.
    bus.mode_311 = 1'b1; forced_cnt = 4'd7;
    bus.btn_311 = 1'b1; tick(1);
    bus.btn_311 = 1'b0; tick(6);
    check_val("auto_ign_press", bus.ud_311, 1);

    // Press pulse in the cycle mode falls to manual is honoured.
    bus.btn_311 = 1'b1; tick(1);
    bus.btn_311 = 1'b0; tick(2);
    bus.mode_311 = 1'b0; tick(1);
    check_val("mode_fall_ud", bus.ud_311, 0);
    check_val("mode_fall_dir", bus.dir_chg_311, 1);

    // Reset with ud low.
    tick(2);
    do_reset(1);
    check_val("midrst_ud", bus.ud_311, 1);
    check_val("midrst_dir", bus.dir_chg_311, 0);
`else
    forced_cnt = 4'd7;
    // Clean 40-cycle press: toggle 19 edges after the press.
    bus.btn_311 = 1'b1; tick(18);
    check_val("db_early", bus.ud_311, 1);
    tick(1);
    check_val("db_toggle_ud", bus.ud_311, 0);
    check_val("db_toggle_dir", bus.dir_chg_311, 1);
    tick(1);
    check_val("db_dir_end", bus.dir_chg_311, 0);
    tick(20);
    check_val("db_held", bus.ud_311, 0);
    bus.btn_311 = 1'b0; tick(25);
    check_val("db_release", bus.ud_311, 0);

    // Bounce every 3 cycles, then settle high.
    for (int i = 0; i < 10; i++) begin
      bus.btn_311 = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(3);
    end
    check_val("bounce_none", bus.ud_311, 0);
    bus.btn_311 = 1'b1; tick(18);
    check_val("bounce_early", bus.ud_311, 0);
    tick(1);
    check_val("bounce_toggle", bus.ud_311, 1);
    check_val("bounce_dir", bus.dir_chg_311, 1);
    bus.btn_311 = 1'b0; tick(25);

    // Get ud low, then reset in PRESS_WAIT with counter at 10.
    bus.btn_311 = 1'b1; tick(19);
    check_val("pre_rst_ud", bus.ud_311, 0);
    bus.btn_311 = 1'b0; tick(25);
    bus.btn_311 = 1'b1; tick(13);
    reset_311 = 1'b1; tick(1);
    reset_311 = 1'b0;
    check_val("midrst_ud", bus.ud_311, 1);
    check_val("midrst_dir", bus.dir_chg_311, 0);
    tick(18);
    check_val("midrst_early", bus.ud_311, 1);
    tick(1);
    check_val("midrst_toggle", bus.ud_311, 0);
    bus.btn_311 = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ud_dir_ctrl_311.md
Name: ud_dir_ctrl_311

Overview:
- Upstream direction controller for the 4-bit up/down counter; drives its ud_311 input and reads back its count_311 output.
- Manual mode: a debounced push-button toggles the count direction.
- Auto mode: ping-pongs the direction so the counter sweeps LOWER..UPPER..LOWER and never wraps.
- Single clock domain shared with the counter.

Parameters:
- W, 4, count width; must match the counter.
- UPPER, 15, top of the auto sweep; requires UPPER - LOWER >= 2 and UPPER <= 2^W - 1.
- LOWER, 0, bottom of the auto sweep.
- DB_CYCLES, 16, number of consecutive stable synchronized button samples needed to accept a press or release (>= 2).

Ports:
- clk_311  in  1  system clock, rising edge.
- reset_311  in  1  synchronous reset, active-high.
- btn_311  in  1  raw asynchronous push-button, active-high.
- mode_311  in  1  0 = manual toggle, 1 = auto ping-pong.
- count_311  in  W  registered counter value, fed back.
- ud_311  out  1  direction to the counter: 1 = up, 0 = down; registered.
- dir_chg_311  out  1  one-cycle pulse whenever ud_311 changes; registered.

Behaviour:
- Reset: on a clock edge with reset_311=1:
  - ud_311 = 1, dir_chg_311 = 0.
  - Synchronizer flops = 0, debounce counter = 0, FSM = IDLE.
  - Reset overrides every other event in the same cycle, including mid-debounce and mid-sweep.
- Synchronizer: btn_311 passes through 2 flops before any use (btn_s).
- Debounce FSM:
  - IDLE: btn_s = 1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: counter increments while btn_s = 1. btn_s = 0 -> IDLE. Counter reaches DB_CYCLES-1 -> PRESSED, with a one-cycle internal press pulse.
  - PRESSED: btn_s = 0 -> REL_WAIT, counter cleared.
  - REL_WAIT: counter increments while btn_s = 0. btn_s = 1 -> PRESSED. Counter reaches DB_CYCLES-1 -> IDLE.
  - Exactly one press pulse per accepted press, however long the button is held.
- Manual mode (mode_311 = 0): press pulse -> ud_311 <= ~ud_311 on the next edge. count_311 is ignored.
- Auto mode (mode_311 = 1): button presses are ignored (the FSM still runs). Look-ahead compensates for the counter's one-cycle register delay:
  - ud_311 = 1 and count_311 == UPPER-1 -> ud_311 <= 0. The counter still steps to UPPER, then reverses. Sequence: ..., UPPER-1, UPPER, UPPER-1, ...
  - ud_311 = 0 and count_311 == LOWER+1 -> ud_311 <= 1. Sequence: ..., LOWER+1, LOWER, LOWER+1, ...
  - Count outside [LOWER, UPPER] (e.g. on entry to auto mode): no reversal until the counter reaches a trigger value. Wrap-around then occurs in the counter, not here.
- Mode changes take effect on the next edge. ud_311 keeps its current value across a mode change.
- A press pulse arriving in the same cycle that mode_311 goes 1 -> 0 is honoured (manual rules apply to that cycle's registered mode_311).
- dir_chg_311 = 1 for exactly the cycle after ud_311 changes value; otherwise 0.
- Latencies:
  - Button to ud_311 change: 2 synchronizer cycles + DB_CYCLES + 1.
  - Auto count to ud_311 change: 1 cycle.

Optional Feature:
- Macro BTN_DEBOUNCE_EN.
- Defined: debounce FSM and DB_CYCLES behave as above.
- Undefined: FSM and counter are omitted. The press pulse is a rising-edge detect on btn_s, giving a one-cycle pulse 3 cycles after btn_311 rises. DB_CYCLES is unused.

Test Plan:
- Reset then hold: reset_311 = 1 for 8 cycles, then 0, mode_311 = 1, counter instantiated -> ud_311 = 1 immediately after reset; count sweeps 0..15, 14..0, 1... with no 15->0 or 0->15 wrap; dir_chg_311 pulses once at each reversal.
- Manual clean press: mode_311 = 0, btn_311 = 1 for 40 cycles -> exactly one toggle; ud_311 goes 1 -> 0 at cycle 2 + 16 + 1 = 19 after the press; one dir_chg_311 pulse.
- Bounce rejection: btn_311 toggles every 3 cycles for 30 cycles, then settles at 1 -> one toggle only, occurring 19 cycles after settling.
- Auto boundary: force count_311 = 14 with ud_311 = 1 -> ud_311 = 0 next cycle. Force count_311 = 1 with ud_311 = 0 -> ud_311 = 1 next cycle. Force count_311 = 15 with ud_311 = 1 -> no change.
- Mid-operation reset: assert reset_311 during PRESS_WAIT (counter = 10) with ud_311 = 0 -> next cycle ud_311 = 1 and dir_chg_311 = 0; holding btn_311 after release of reset needs a full 19 cycles to toggle.
- Macro off: build without BTN_DEBOUNCE_EN, mode_311 = 0, single-cycle btn_311 pulse -> ud_311 toggles exactly 4 cycles later.
